// File: rtl/md6_pad_responder.sv
// Mega Drive 6-button pad responder: samples the host TH select line and drives
// the active-low D5..D0 pins from a 12-bit button vector, including 6-button ID phases.
module md6_pad_responder #(
   parameter int TIMEOUT_CYC = 18000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        th_in,
   input  logic [11:0] btn,
   input  logic        six_btn_en,
   output logic [5:0]  pad_out,
   output logic [2:0]  phase
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC);

   logic          th_meta_reg;
   logic          th_s_reg;
   logic          th_prev_reg;
   logic [2:0]    cnt_reg;
   logic [2:0]    cnt_next;
   logic [TW-1:0] timer_reg;
   logic [TW-1:0] timer_next;
   logic [5:0]    pad_reg;
   logic [5:0]    pad_next;

   logic th_edge;
   logic th_fall;
   logic timeout_due;

   logic b_up, b_down, b_left, b_right, b_a, b_b, b_c, b_start;
   logic b_z, b_y, b_x, b_mode;

   assign {b_mode, b_x, b_y, b_z, b_start, b_c, b_b, b_a,
           b_right, b_left, b_down, b_up} = btn;

   assign th_edge     = th_s_reg ^ th_prev_reg;
   assign th_fall     = th_prev_reg & ~th_s_reg;
   assign timeout_due = (timer_reg == TIMER_MAX);

   // Synchroniser and edge history; idle level of TH is high.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         th_meta_reg <= 1'b1;
         th_s_reg    <= 1'b1;
         th_prev_reg <= 1'b1;
      end else begin
         th_meta_reg <= th_in;
         th_s_reg    <= th_meta_reg;
         th_prev_reg <= th_s_reg;
      end
   end

   // A falling edge landing on the timeout cycle starts a fresh sequence at 1.
   always_comb begin
      cnt_next = cnt_reg;
      if (th_fall) begin
         if (timeout_due)
            cnt_next = 3'd1;
         else if (cnt_reg >= 3'd4)
            cnt_next = 3'd4;
         else
            cnt_next = cnt_reg + 3'd1;
      end else if (timeout_due) begin
         cnt_next = 3'd0;
      end
   end

   always_comb begin
      timer_next = timer_reg;
      if (th_edge)
         timer_next = '0;
      else if (!timeout_due)
         timer_next = timer_reg + 1'b1;
   end

   // Row select uses the post-update count so the pins settle 3 cycles after a TH pin edge.
   always_comb begin
      pad_next = ~{b_c, b_b, b_right, b_left, b_down, b_up};
      if (th_s_reg) begin
         if (six_btn_en && cnt_next == 3'd3)
            pad_next = ~{b_c, b_b, b_mode, b_x, b_y, b_z};
      end else begin
         pad_next = {~b_start, ~b_a, 1'b0, 1'b0, ~b_down, ~b_up};
         if (six_btn_en && cnt_next == 3'd3)
            pad_next = {~b_start, ~b_a, 4'b0000};
         else if (six_btn_en && cnt_next == 3'd4)
            pad_next = {~b_start, ~b_a, 4'b1111};
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt_reg   <= 3'd0;
         timer_reg <= '0;
         pad_reg   <= 6'h3F;
      end else begin
         cnt_reg   <= cnt_next;
         timer_reg <= timer_next;
         pad_reg   <= pad_next;
      end
   end

   assign pad_out = pad_reg;
   assign phase   = cnt_reg;

endmodule

// File: tb/tb_md6_pad_responder.sv
// Directed bench for md6_pad_responder: TH pulse sequences, 6-button phases,
// timeout handling and mid-sequence reset.
module tb_md6_pad_responder;

   localparam int T = 18000;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        th_in;
   logic [11:0] btn;
   logic        six_btn_en;
   logic [5:0]  pad_out;
   logic [2:0]  phase;

   int checks = 0;
   int errors = 0;

   md6_pad_responder #(.TIMEOUT_CYC(T)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .th_in      (th_in),
      .btn        (btn),
      .six_btn_en (six_btn_en),
      .pad_out    (pad_out),
      .phase      (phase)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic wait_neg(input int n);
      for (int i = 0; i < n; i++) @(negedge clk_sys);
   endtask

   task automatic apply_reset();
      th_in = 1'b1;
      reset = 1'b1;
      wait_neg(2);
      reset = 1'b0;
   endtask

   // Low half then high half of one TH pulse, 10 clocks each.
   task automatic pulse_low(input string tag, input logic [5:0] exp_pad, input logic [2:0] exp_ph);
      th_in = 1'b0;
      wait_neg(10);
      check({tag, "_low_pad"}, {2'b00, pad_out}, {2'b00, exp_pad});
      check({tag, "_low_ph"}, {5'b0, phase}, {5'b0, exp_ph});
   endtask

   task automatic pulse_high(input string tag, input logic [5:0] exp_pad);
      th_in = 1'b1;
      wait_neg(10);
      check({tag, "_high_pad"}, {2'b00, pad_out}, {2'b00, exp_pad});
   endtask

   initial begin
      btn        = 12'h000;
      six_btn_en = 1'b0;
      apply_reset();
      check("rst_pad", {2'b00, pad_out}, 8'h3F);
      check("rst_ph", {5'b0, phase}, 8'h00);

      // up + B with TH high
      btn = 12'h021;
      wait_neg(3);
      check("th1_upB", {2'b00, pad_out}, 8'h2E);
      // start + A + up + down with TH low
      btn   = 12'h093;
      th_in = 1'b0;
      wait_neg(3);
      check("th0_AstUD", {2'b00, pad_out}, 8'h00);
      th_in = 1'b1;
      btn   = 12'h000;
      wait_neg(10);
      // button change with no TH activity shows one clock later
      btn = 12'h008;
      wait_neg(1);
      check("btn_right_1clk", {2'b00, pad_out}, 8'h37);
      btn = 12'h000;
      wait_neg(1);

      // 6-button sequence
      apply_reset();
      six_btn_en = 1'b1;
      pulse_low("s6_p1", 6'h33, 3'd1);
      pulse_high("s6_p1", 6'h3F);
      pulse_low("s6_p2", 6'h33, 3'd2);
      pulse_high("s6_p2", 6'h3F);
      pulse_low("s6_p3", 6'h30, 3'd3);
      btn = 12'h400;
      pulse_high("s6_p3x", 6'h3B);
      btn = 12'h000;
      pulse_low("s6_p4", 6'h3F, 3'd4);
      pulse_high("s6_p4", 6'h3F);
      wait_neg(T + 10);
      check("timeout_ph", {5'b0, phase}, 8'h00);
      pulse_low("s6_after_to", 6'h33, 3'd1);
      pulse_high("s6_after_to", 6'h3F);

      // 3-button mode never emits the ID row
      apply_reset();
      six_btn_en = 1'b0;
      for (int p = 0; p < 5; p++) begin
         th_in = 1'b0;
         wait_neg(10);
         check($sformatf("s3_p%0d_low", p + 1), {2'b00, pad_out}, 8'h33);
         th_in = 1'b1;
         wait_neg(10);
         check($sformatf("s3_p%0d_high", p + 1), {2'b00, pad_out}, 8'h3F);
      end

      // falling edge detected on the exact timeout cycle
      apply_reset();
      six_btn_en = 1'b1;
      pulse_low("ex_p1", 6'h33, 3'd1);
      pulse_high("ex_p1", 6'h3F);
      th_in = 1'b0;
      wait_neg(10);
      th_in = 1'b1;
      wait_neg(T + 1);
      th_in = 1'b0;
      wait_neg(10);
      check("exact_to_ph", {5'b0, phase}, 8'h01);
      check("exact_to_pad", {2'b00, pad_out}, 8'h33);
      th_in = 1'b1;
      wait_neg(10);

      // reset mid-sequence
      apply_reset();
      pulse_low("mid_p1", 6'h33, 3'd1);
      pulse_high("mid_p1", 6'h3F);
      pulse_low("mid_p2", 6'h33, 3'd2);
      pulse_high("mid_p2", 6'h3F);
      apply_reset();
      check("mid_rst_ph", {5'b0, phase}, 8'h00);
      pulse_low("mid_after", 6'h33, 3'd1);
      pulse_high("mid_after", 6'h3F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
